neuron_stream_loader: RTL and testbench

- Front-end controller for one intra-parallel neuron (N-bit signed MAC tree, saturated ReLU, registered output, enable-gated).
- Accepts a serial valid/ready stream of N-bit words, packs N_INPUTS weights and N_INPUTS activations into the neuron's packed W / X_N buses, and sequences the neuron's enable.
- Captures the neuron result and returns it on a valid/ready result port.
- Weights can be retained across inferences to avoid reloading.

---
 rtl/neuron_stream_loader_pkg.sv | 22 ++
 rtl/neuron_stream_loader_vector_pack_reg.sv | 35 +++
 rtl/neuron_stream_loader.sv | 160 ++++++++++++++++
 tb/tb_neuron_stream_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_stream_loader_pkg.sv
// Shared definitions for the neuron stream loader: FSM encoding, fire length
// and the packed-bus slice layout used by both the loader and the neuron.
package neuron_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_FIRE1   = 3'd3,
    ST_FIRE2   = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_RESULT  = 3'd6
  } state_t;

  localparam int unsigned NEU_EN_CYCLES = 32'd2;

  // Word idx of a packed vector occupies [slice_lo(idx, width) +: width].
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/neuron_stream_loader_vector_pack_reg.sv
// N_INPUTS x N register file with one indexed write port and a flat packed
// read-out laid out exactly as the neuron expects.
module vector_pack_reg
  import neuron_stream_loader_pkg::*;
#(
  parameter int N        = 8,
  parameter int N_INPUTS = 32,
  parameter int IDX_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [N-1:0]          wdata,
  output logic [N*N_INPUTS-1:0] bus
);

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_word
    logic [N-1:0] word_r;

    // Each word loads only on a write addressed to it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_r <= {N{1'b0}};
      end else if (we && (idx == IDX_W'(i))) begin
        word_r <= wdata;
      end else begin
        word_r <= word_r;
      end
    end

    assign bus[slice_lo(i, N) +: N] = word_r;
  end

endmodule

// File: rtl/neuron_stream_loader.sv
// Front-end controller for one neuron: packs a serial word stream into the
// weight/activation buses, pulses the neuron enable and returns the result.
module neuron_stream_loader
  import neuron_stream_loader_pkg::*;
#(
  parameter int N        = 8,
  parameter int N_INPUTS = 32,
  parameter int CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reuse_w,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N-1:0]          s_data,
  output logic [N*N_INPUTS-1:0] w_bus,
  output logic [N*N_INPUTS-1:0] x_bus,
  output logic                  neu_en,
  input  logic [N-1:0]          neu_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N-1:0]          m_data,
  output logic                  busy,
  output logic                  w_loaded
);

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               hs_s;
  logic               last_s;
  logic               w_we_s;
  logic               x_we_s;

  assign hs_s   = s_valid && s_ready;
  assign last_s = (cnt_r == CNT_W'(N_INPUTS - 1));
  assign w_we_s = (state_r == ST_LOAD_W) && hs_s;
  assign x_we_s = (state_r == ST_LOAD_X) && hs_s;

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = (reuse_w && w_loaded) ? ST_LOAD_X : ST_LOAD_W;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (hs_s && last_s) begin
          next_state_s = ST_LOAD_X;
        end else begin
          next_state_s = ST_LOAD_W;
        end
      end
      ST_LOAD_X: begin
        if (hs_s && last_s) begin
          next_state_s = ST_FIRE1;
        end else begin
          next_state_s = ST_LOAD_X;
        end
      end
      ST_FIRE1:   next_state_s = ST_FIRE2;
      ST_FIRE2:   next_state_s = ST_CAPTURE;
      ST_CAPTURE: next_state_s = ST_RESULT;
      ST_RESULT: begin
        if (m_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESULT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register; handshake outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      s_ready <= 1'b0;
      neu_en  <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      s_ready <= (next_state_s == ST_LOAD_W) || (next_state_s == ST_LOAD_X);
      neu_en  <= (next_state_s == ST_FIRE1) || (next_state_s == ST_FIRE2);
      m_valid <= (next_state_s == ST_RESULT);
      busy    <= (next_state_s != ST_IDLE);
    end
  end

  // Word index: advances per accepted word, wraps at the end of each vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s && ((state_r == ST_LOAD_W) || (state_r == ST_LOAD_X))) begin
      cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Held weights are invalid from the moment a fresh weight load begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_loaded <= 1'b0;
    end else if ((state_r == ST_IDLE) && (next_state_s == ST_LOAD_W)) begin
      w_loaded <= 1'b0;
    end else if (w_we_s && last_s) begin
      w_loaded <= 1'b1;
    end else begin
      w_loaded <= w_loaded;
    end
  end

  // Result capture one cycle after the neuron output register has loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= {N{1'b0}};
    end else if (state_r == ST_CAPTURE) begin
      m_data <= neu_out;
    end else begin
      m_data <= m_data;
    end
  end

  vector_pack_reg #(
    .N        (N),
    .N_INPUTS (N_INPUTS),
    .IDX_W    (CNT_W)
  ) u_w_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we_s),
    .idx   (cnt_r),
    .wdata (s_data),
    .bus   (w_bus)
  );

  vector_pack_reg #(
    .N        (N),
    .N_INPUTS (N_INPUTS),
    .IDX_W    (CNT_W)
  ) u_x_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (x_we_s),
    .idx   (cnt_r),
    .wdata (s_data),
    .bus   (x_bus)
  );

endmodule

// File: tb/tb_neuron_stream_loader.sv
// Randomised self-checking bench for neuron_stream_loader (N=8, N_INPUTS=4)
// with a behavioural neuron attached and an arithmetic reference model.
module tb_neuron_stream_loader;
  import neuron_stream_loader_pkg::*;

  localparam int N  = 8;
  localparam int NI = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            reuse_w = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [N-1:0]    s_data = '0;
  logic [N*NI-1:0] w_bus;
  logic [N*NI-1:0] x_bus;
  logic            neu_en;
  logic [N-1:0]    neu_out;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [N-1:0]    m_data;
  logic            busy;
  logic            w_loaded;

  int n_vec = 0;
  int n_err = 0;

  int cur_w [NI];
  int cur_x [NI];
  int model_w [NI];
  bit model_w_loaded = 1'b0;

  always #5 clk = ~clk;

  neuron_stream_loader #(.N(N), .N_INPUTS(NI), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w_bus(w_bus), .x_bus(x_bus), .neu_en(neu_en), .neu_out(neu_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .w_loaded(w_loaded)
  );

  // Behavioural neuron: accumulator then saturated-ReLU output, both gated by enable.
  int nacc;
  logic [N-1:0] nout;

  function automatic int bus_dot(input logic [N*NI-1:0] a, input logic [N*NI-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < NI; i++) begin
      s += int'($signed(a[i*N +: N])) * int'($signed(b[i*N +: N]));
    end
    return s;
  endfunction

  function automatic int sat_relu(input int v);
    if (v < 0) return 0;
    else if (v > 127) return 127;
    else return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nacc <= 0;
      nout <= '0;
    end else if (neu_en) begin
      nacc <= bus_dot(w_bus, x_bus);
      nout <= 8'(sat_relu(nacc));
    end
  end
  assign neu_out = nout;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_w_bus"}, 64'(w_bus), 64'd0);
    check_eq({tag, "_x_bus"}, 64'(x_bus), 64'd0);
    check_eq({tag, "_m_data"}, 64'(m_data), 64'd0);
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check_eq({tag, "_neu_en"}, 64'(neu_en), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_w_loaded"}, 64'(w_loaded), 64'd0);
  endtask

  // One full inference; entered and left on a falling clock edge.
  task automatic run_case(input string tag, input bit reuse, input bit stall, input int hold);
    int q[$];
    bit load_w;
    int cyc;
    int en_cnt;
    int exp_res;
    logic [N*NI-1:0] ew;
    logic [N*NI-1:0] ex;

    load_w = !(reuse && model_w_loaded);
    if (load_w) begin
      for (int i = 0; i < NI; i++) begin
        q.push_back(cur_w[i]);
        model_w[i] = cur_w[i];
      end
    end
    for (int i = 0; i < NI; i++) q.push_back(cur_x[i]);
    exp_res = 0;
    for (int i = 0; i < NI; i++) begin
      exp_res += model_w[i] * cur_x[i];
      ew[i*N +: N] = 8'(model_w[i]);
      ex[i*N +: N] = 8'(cur_x[i]);
    end
    exp_res = sat_relu(exp_res);

    start = 1'b1;
    reuse_w = reuse;
    @(negedge clk);
    start = 1'b0;
    reuse_w = 1'b0;
    check_eq({tag, "_busy_after_start"}, 64'(busy), 64'd1);

    cyc = 0;
    while ((q.size() > 0) && (cyc < 200)) begin
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = 8'(q[0]);
      if (s_valid && s_ready) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    check_eq({tag, "_words_left"}, 64'(q.size()), 64'd0);
    model_w_loaded = 1'b1;

    // Now in cycle c+1 after the last activation handshake.
    check_eq({tag, "_w_bus"}, 64'(w_bus), 64'(ew));
    check_eq({tag, "_x_bus"}, 64'(x_bus), 64'(ex));
    check_eq({tag, "_s_ready_off"}, 64'(s_ready), 64'd0);
    check_eq({tag, "_w_loaded"}, 64'(w_loaded), 64'd1);
    en_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      check_eq({tag, "_neu_en_c", $sformatf("%0d", k)}, 64'(neu_en), (k <= 2) ? 64'd1 : 64'd0);
      check_eq({tag, "_m_valid_c", $sformatf("%0d", k)}, 64'(m_valid), (k == 4) ? 64'd1 : 64'd0);
      if (neu_en) en_cnt++;
      if (k < 4) @(negedge clk);
    end
    check_eq({tag, "_en_cycles"}, 64'(en_cnt), 64'(NEU_EN_CYCLES));
    check_eq({tag, "_m_data"}, 64'(m_data), 64'(8'(exp_res)));

    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq({tag, "_hold_m_valid"}, 64'(m_valid), 64'd1);
      check_eq({tag, "_hold_m_data"}, 64'(m_data), 64'(8'(exp_res)));
      check_eq({tag, "_hold_w_bus"}, 64'(w_bus), 64'(ew));
      check_eq({tag, "_hold_x_bus"}, 64'(x_bus), 64'(ex));
      check_eq({tag, "_hold_neu_en"}, 64'(neu_en), 64'd0);
    end

    m_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    start = 1'b0;
    check_eq({tag, "_m_valid_drop"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_start_ignored"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic signed [N-1:0] b;
    int cyc;
    int taken;

    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < NI; i++) begin cur_w[i] = 1; cur_x[i] = i + 1; end
    run_case("basic", 1'b0, 1'b0, 0);
    check_eq("basic_w_bus_const", 64'(w_bus), 64'h0101_0101);

    for (int i = 0; i < NI; i++) begin cur_w[i] = 99; cur_x[i] = 2; end
    run_case("reuse", 1'b1, 1'b0, 0);

    for (int i = 0; i < NI; i++) begin cur_w[i] = 1; cur_x[i] = i + 1; end
    run_case("stall", 1'b0, 1'b1, 0);
    check_eq("stall_w_bus_const", 64'(w_bus), 64'h0101_0101);

    for (int i = 0; i < NI; i++) begin cur_w[i] = 127; cur_x[i] = 127; end
    run_case("saturate", 1'b0, 1'b0, 0);

    for (int i = 0; i < NI; i++) begin cur_w[i] = -1; cur_x[i] = 5; end
    run_case("negative", 1'b0, 1'b0, 0);

    for (int i = 0; i < NI; i++) begin cur_w[i] = 1; cur_x[i] = i + 1; end
    run_case("backpressure", 1'b0, 1'b0, 10);

    // Reset after the weights and two activations have been accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    taken = 0;
    cyc = 0;
    while ((taken < NI + 2) && (cyc < 100)) begin
      s_valid = 1'b1;
      s_data = 8'(taken + 3);
      if (s_ready) taken++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    check_eq("midload_words", 64'(taken), 64'(NI + 2));
    rst = 1'b1;
    #1;
    check_idle_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b0;
    model_w_loaded = 1'b0;
    @(negedge clk);
    check_idle_outputs("midload_after");
    for (int i = 0; i < NI; i++) begin cur_w[i] = 3; cur_x[i] = i - 1; end
    run_case("reload_after_reset", 1'b1, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NI; i++) begin
        b = 8'($urandom);
        cur_w[i] = int'(b);
        b = 8'($urandom);
        cur_x[i] = int'(b);
      end
      run_case($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
